ysyx_23060042_seq: RTL and testbench

Multi-cycle sequencer for the single-issue RV32 core. It steps each instruction through fetch, decode, execute, memory and write-back by driving the instruction-register, register-file and PC write strobes and the instruction/data memory request handshakes. It sits beside the instruction decoder and takes the decoded `opcode` as its only instruction input. It also provides halt/error termination for simulation, a retired-instruction counter and a bus-timeout watchdog.

---
 rtl/ysyx_23060042_seq.sv | 168 ++++++++++++++++
 tb/tb_ysyx_23060042_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060042_seq.sv
// Multi-cycle FETCH/IWAIT/DECODE/EXEC/MEM/WB sequencer with halt/error stop, retire counter and bus watchdog.
// ALU ops take 5 cycles and loads/stores 6, plus one per bus wait cycle. A wait longer than TIMEOUT+1 cycles ends in ERR.
module ysyx_23060042_seq #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  output logic        imem_req,
  input  logic        imem_rvalid,
  output logic        ir_we,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_rvalid,
  output logic        rf_we,
  output logic        pc_we,
  output logic        halt,
  output logic        err,
  output logic [2:0]  state_o,
  output logic [31:0] inst_cnt
);

  localparam logic [15:0] WDOG_MAX = 16'(TIMEOUT);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_IWAIT  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] wdog;
  logic [15:0] wdog_nxt;

  // Instructions that retire through WB without touching data memory.
  function automatic logic is_wb_only(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_IMM, OP_OP: is_wb_only = 1'b1;
      default:                                                     is_wb_only = 1'b0;
    endcase
  endfunction

  function automatic logic writes_rd(input logic [6:0] op);
    writes_rd = (op != OP_STORE) && (op != OP_BRANCH);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      wdog     <= 16'd0;
      inst_cnt <= 32'd0;
    end else begin
      state <= state_nxt;
      wdog  <= wdog_nxt;
      if (state == S_WB) begin
        inst_cnt <= inst_cnt + 32'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    wdog_nxt  = wdog;
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    rf_we     = 1'b0;
    pc_we     = 1'b0;
    halt      = 1'b0;
    err       = 1'b0;
    state_o   = state;

    case (state)
      S_FETCH: begin
        imem_req  = 1'b1;
        wdog_nxt  = 16'd0;
        state_nxt = S_IWAIT;
      end
      S_IWAIT: begin
        // A response on the last allowed cycle still wins over the timeout.
        if (imem_rvalid) begin
          ir_we     = 1'b1;
          state_nxt = S_DECODE;
        end else if (wdog == WDOG_MAX) begin
          state_nxt = S_ERR;
        end else begin
          wdog_nxt = wdog + 16'd1;
        end
      end
      S_DECODE: begin
        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (opcode == OP_LOAD) begin
          dmem_req  = 1'b1;
          wdog_nxt  = 16'd0;
          state_nxt = S_MEM;
        end else if (opcode == OP_STORE) begin
          dmem_req  = 1'b1;
          dmem_we   = 1'b1;
          wdog_nxt  = 16'd0;
          state_nxt = S_MEM;
        end else if (opcode == OP_SYSTEM) begin
          state_nxt = S_HALT;
        end else if (is_wb_only(opcode)) begin
          state_nxt = S_WB;
        end else begin
          state_nxt = S_ERR;
        end
      end
      S_MEM: begin
        if (dmem_rvalid) begin
          state_nxt = S_WB;
        end else if (wdog == WDOG_MAX) begin
          state_nxt = S_ERR;
        end else begin
          wdog_nxt = wdog + 16'd1;
        end
      end
      S_WB: begin
        pc_we     = 1'b1;
        rf_we     = writes_rd(opcode);
        state_nxt = S_FETCH;
      end
      S_HALT: begin
        halt = 1'b1;
      end
      S_ERR: begin
        err = 1'b1;
      end
      default: begin
        state_nxt = S_ERR;
      end
    endcase

    // Reset silences every strobe, including ir_we's direct path from imem_rvalid.
    if (rst) begin
      imem_req = 1'b0;
      ir_we    = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      rf_we    = 1'b0;
      pc_we    = 1'b0;
      halt     = 1'b0;
      err      = 1'b0;
      state_o  = 3'd0;
    end
  end

endmodule

// File: tb/tb_ysyx_23060042_seq.sv
// Bench for ysyx_23060042_seq: per-instruction phase model drives inputs and predicts outputs every cycle.
module tb_ysyx_23060042_seq;

  localparam int T = 3;

  localparam logic [7:0] M_IMREQ = 8'h80;
  localparam logic [7:0] M_IRWE  = 8'h40;
  localparam logic [7:0] M_DREQ  = 8'h20;
  localparam logic [7:0] M_DWE   = 8'h10;
  localparam logic [7:0] M_RFWE  = 8'h08;
  localparam logic [7:0] M_PCWE  = 8'h04;
  localparam logic [7:0] M_HALT  = 8'h02;
  localparam logic [7:0] M_ERR   = 8'h01;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] SYSTEM = 7'b1110011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] OPIMM  = 7'b0010011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  opcode = 7'd0;
  logic        imem_rvalid = 1'b0;
  logic        dmem_rvalid = 1'b0;
  logic        imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, halt, err;
  logic [2:0]  state_o;
  logic [31:0] inst_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_cnt = 32'd0;
  logic [6:0]  legal_ops [9] = '{7'b0000011, 7'b0100011, 7'b0110111, 7'b0010111,
                                 7'b1101111, 7'b1100111, 7'b1100011, 7'b0010011, 7'b0110011};

  ysyx_23060042_seq #(.TIMEOUT(T)) dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .imem_req    (imem_req),
    .imem_rvalid (imem_rvalid),
    .ir_we       (ir_we),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_rvalid (dmem_rvalid),
    .rf_we       (rf_we),
    .pc_we       (pc_we),
    .halt        (halt),
    .err         (err),
    .state_o     (state_o),
    .inst_cnt    (inst_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic rnd();
    return 1'($urandom);
  endfunction

  function automatic logic [6:0] rop();
    return 7'($urandom);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs on the falling edge, then compare the settled outputs.
  task automatic step(input logic r, input logic [2:0] es, input logic [7:0] estr,
                      input logic iv, input logic dv, input logic [6:0] op, input logic chk_cnt);
    @(negedge clk);
    rst = r;
    imem_rvalid = iv;
    dmem_rvalid = dv;
    opcode = op;
    #1;
    check("state_o", {29'd0, state_o}, {29'd0, es});
    check("strobes", {24'd0, imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, halt, err},
          {24'd0, estr});
    if (chk_cnt) check("inst_cnt", inst_cnt, model_cnt);
  endtask

  task automatic do_reset(input int n);
    model_cnt = 32'd0;
    step(1'b1, 3'd0, 8'h00, rnd(), rnd(), rop(), 1'b0);
    for (int i = 1; i < n; i++) step(1'b1, 3'd0, 8'h00, rnd(), rnd(), rop(), 1'b1);
  endtask

  task automatic hold(input int n, input logic [2:0] st, input logic [7:0] str);
    for (int i = 0; i < n; i++) step(1'b0, st, str, rnd(), rnd(), rop(), 1'b1);
  endtask

  // ended: 0 retired, 1 halted, 2 error, 3 left in MEM for a reset to abort.
  task automatic run_instr(input logic [6:0] op, input int iw, input int dw,
                           input logic abort_in_mem, output int ended);
    logic [7:0] estr;
    logic       is_mem;
    ended = 0;
    step(1'b0, 3'd0, M_IMREQ, rnd(), rnd(), rop(), 1'b1);
    for (int k = 0; k < iw && k <= T; k++) step(1'b0, 3'd1, 8'h00, 1'b0, rnd(), rop(), 1'b1);
    if (iw > T) begin
      ended = 2;
      return;
    end
    step(1'b0, 3'd1, M_IRWE, 1'b1, rnd(), rop(), 1'b1);
    step(1'b0, 3'd2, 8'h00, rnd(), rnd(), op, 1'b1);
    is_mem = (op == LOAD) || (op == STORE);
    if (op == LOAD)        estr = M_DREQ;
    else if (op == STORE)  estr = M_DREQ | M_DWE;
    else                   estr = 8'h00;
    if (op == SYSTEM) ended = 1;
    else if (!is_mem && !(op inside {legal_ops})) ended = 2;
    step(1'b0, 3'd3, estr, rnd(), rnd(), op, 1'b1);
    if (ended != 0) return;
    if (is_mem) begin
      for (int k = 0; k < dw && k <= T; k++) begin
        step(1'b0, 3'd4, 8'h00, rnd(), 1'b0, op, 1'b1);
        if (abort_in_mem) begin
          ended = 3;
          return;
        end
      end
      if (dw > T) begin
        ended = 2;
        return;
      end
      step(1'b0, 3'd4, 8'h00, rnd(), 1'b1, op, 1'b1);
    end
    estr = M_PCWE | (((op == STORE) || (op == BRANCH)) ? 8'h00 : M_RFWE);
    step(1'b0, 3'd5, estr, rnd(), rnd(), op, 1'b1);
    model_cnt = model_cnt + 32'd1;
  endtask

  initial begin
    int ended;

    // Reset, then three back-to-back OP-IMM with immediate fetch data.
    do_reset(3);
    for (int i = 0; i < 3; i++) begin
      run_instr(OPIMM, 0, 0, 1'b0, ended);
      check("alu_ended", ended, 0);
    end

    // Load with a late response, then a store with an immediate one.
    run_instr(LOAD, 0, 2, 1'b0, ended);
    check("load_ended", ended, 0);
    run_instr(STORE, 1, 0, 1'b0, ended);
    check("store_ended", ended, 0);

    // Fetch answered on the last allowed IWAIT cycle is accepted.
    run_instr(OPIMM, T, 0, 1'b0, ended);
    check("iwait_edge_ended", ended, 0);
    // Data answered on the last allowed MEM cycle is accepted.
    run_instr(LOAD, 0, T, 1'b0, ended);
    check("mem_edge_ended", ended, 0);

    // Fetch never answered: ERR after T+1 IWAIT cycles, held.
    run_instr(OPIMM, T + 1, 0, 1'b0, ended);
    check("iwait_timeout_ended", ended, 2);
    hold(6, 3'd7, M_ERR);

    // Reset clears ERR; data timeout also ends in ERR.
    do_reset(2);
    run_instr(STORE, 0, T + 1, 1'b0, ended);
    check("mem_timeout_ended", ended, 2);
    hold(4, 3'd7, M_ERR);

    // Illegal opcode.
    do_reset(2);
    run_instr(OPIMM, 0, 0, 1'b0, ended);
    run_instr(7'b0000000, 0, 0, 1'b0, ended);
    check("illegal_ended", ended, 2);
    hold(5, 3'd7, M_ERR);

    // SYSTEM halts without retiring and no further fetch follows.
    do_reset(2);
    run_instr(OPIMM, 0, 0, 1'b0, ended);
    run_instr(SYSTEM, 1, 0, 1'b0, ended);
    check("system_ended", ended, 1);
    hold(20, 3'd6, M_HALT);

    // Reset while a load is waiting in MEM.
    do_reset(2);
    run_instr(OPIMM, 0, 0, 1'b0, ended);
    run_instr(LOAD, 0, 2, 1'b1, ended);
    check("abort_ended", ended, 3);
    do_reset(3);
    run_instr(OPIMM, 0, 0, 1'b0, ended);
    check("after_abort_ended", ended, 0);

    // Random legal stream with random waits; responses outside their windows are noise.
    for (int i = 0; i < 40; i++) begin
      run_instr(legal_ops[$urandom_range(0, 8)], $urandom_range(0, T), $urandom_range(0, T),
                1'b0, ended);
      check("rand_ended", ended, 0);
    end
    step(1'b0, 3'd0, M_IMREQ, rnd(), rnd(), rop(), 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
